// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding and width helpers for the bus arbiter.
package bus_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  function automatic int be_width(input int xlen);
    return xlen / 8;
  endfunction
  function automatic int idx_width(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational requester selection, fixed priority or round-robin from a pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          rr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [N-1:0] hi;
  // Requests at or above the pointer win; otherwise wrap to the lowest request overall.
  always_comb begin
    hi = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) hi[i] = req_i[i] && (!rr_i || i >= int'(ptr_i));
    for (int i = N - 1; i >= 0; i--) if (hi[i] || (~|hi && req_i[i])) idx_o = IW'(i);
  end
  assign gnt_o = |req_i ? N'(1) << idx_o : '0;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: arbitrates NUM_MASTERS requesters onto one registered bus master port,
// routing ack/read data back to the granted requester with optional timeout abort.
module bus_arbiter import bus_arb_pkg::*; #(
  parameter int XLEN         = 32,
  parameter int NUM_MASTERS  = 2,
  parameter int RR_ARB       = 1,
  parameter int TIMEOUT      = 0,
  parameter int ALIGN_WRITES = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_MASTERS-1:0]                i_req,
  input  logic [NUM_MASTERS-1:0]                i_wr_en,
  input  logic [NUM_MASTERS*XLEN-1:0]           i_addr,
  input  logic [NUM_MASTERS*XLEN-1:0]           i_wr_data,
  input  logic [NUM_MASTERS*be_width(XLEN)-1:0] i_byte_en,
  output logic [NUM_MASTERS-1:0]                o_ready,
  output logic [NUM_MASTERS-1:0]                o_err,
  output logic [XLEN-1:0]                       o_rd_data,
  output logic                                  o_bus_en,
  output logic                                  o_bus_wr_en,
  output logic [XLEN-1:0]                       o_bus_addr,
  output logic [XLEN-1:0]                       o_bus_wr_data,
  output logic [be_width(XLEN)-1:0]             o_bus_byte_en,
  input  logic [XLEN-1:0]                       i_bus_rd_data,
  input  logic                                  i_bus_ack
);
  localparam int BW = be_width(XLEN);
  localparam int IW = idx_width(NUM_MASTERS);
  localparam int CW = idx_width(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, ptr_q, ptr_d, sel_idx;
  logic [NUM_MASTERS-1:0] grant_oh_q, grant_oh_d, sel_oh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bus_en_d, bus_wr_d;
  logic [XLEN-1:0] addr_d, wdata_d, sel_addr;
  logic [BW-1:0] be_d;
  logic ack, tmo, done, live;

  rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
    .req_i(i_req),
    .ptr_i(ptr_q),
    .rr_i (RR_ARB != 0),
    .gnt_o(sel_oh),
    .idx_o(sel_idx)
  );

  // The counter holds the number of BUSY cycles elapsed, so it reads 1 in the first one.
  assign ack      = state_q == BUSY && i_bus_ack;
  assign tmo      = TIMEOUT > 0 && state_q == BUSY && cnt_q == CW'(TIMEOUT);
  assign done     = ack || tmo;
  assign live     = |(i_req & grant_oh_q);
  assign o_ready  = done && live ? grant_oh_q : '0;
  assign o_err    = tmo && !ack && live ? grant_oh_q : '0;
  assign o_rd_data = ack && live ? i_bus_rd_data : '0;
  assign sel_addr = i_addr[sel_idx*XLEN +: XLEN];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    grant_oh_d = grant_oh_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q + CW'(state_q == BUSY);
    bus_en_d = o_bus_en;
    bus_wr_d = o_bus_wr_en;
    addr_d = o_bus_addr;
    wdata_d = o_bus_wr_data;
    be_d = o_bus_byte_en;
    if (state_q == IDLE && |i_req) begin
      state_d = BUSY;
      grant_d = sel_idx;
      grant_oh_d = sel_oh;
      cnt_d = CW'(1);
      bus_en_d = 1'b1;
      bus_wr_d = i_wr_en[sel_idx];
      addr_d = ALIGN_WRITES != 0 && i_wr_en[sel_idx] ? {sel_addr[XLEN-1:2], 2'b00} : sel_addr;
      wdata_d = i_wr_data[sel_idx*XLEN +: XLEN];
      be_d = i_byte_en[sel_idx*BW +: BW];
    end else if (done) begin
      state_d = IDLE;
      grant_oh_d = '0;
      cnt_d = '0;
      ptr_d = grant_q == IW'(NUM_MASTERS - 1) ? '0 : grant_q + 1'b1;
      bus_en_d = 1'b0;
      bus_wr_d = 1'b0;
      addr_d = '0;
      wdata_d = '0;
      be_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      grant_oh_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      o_bus_en <= 1'b0;
      o_bus_wr_en <= 1'b0;
      o_bus_addr <= '0;
      o_bus_wr_data <= '0;
      o_bus_byte_en <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      grant_oh_q <= grant_oh_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      o_bus_en <= bus_en_d;
      o_bus_wr_en <= bus_wr_d;
      o_bus_addr <= addr_d;
      o_bus_wr_data <= wdata_d;
      o_bus_byte_en <= be_d;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: random requests/acks into a round-robin+timeout and a fixed-priority arbiter,
// each checked cycle by cycle against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int N = 3, XL = 32, TO0 = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, wr = '0;
  logic [N*XL-1:0] addr = '0, wd = '0;
  logic [N*4-1:0] be = '0;
  logic [XL-1:0] bus_rd = '0;
  logic bus_ack = 1'b0;
  logic [N-1:0] rdy [2], err [2];
  logic [XL-1:0] rd [2], b_addr [2], b_wd [2];
  logic b_en [2], b_wr [2];
  logic [3:0] b_be [2];
  int n_cmp = 0, n_bad = 0;
  logic mbusy [2], mwr [2];
  int mgnt [2], mptr [2], mcnt [2];
  logic [XL-1:0] maddr [2], mwd [2];
  logic [3:0] mbe [2];

  always #5 clk = ~clk;

  bus_arbiter #(.XLEN(XL), .NUM_MASTERS(N), .RR_ARB(1), .TIMEOUT(TO0), .ALIGN_WRITES(1)) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr_en(wr), .i_addr(addr), .i_wr_data(wd),
    .i_byte_en(be), .o_ready(rdy[0]), .o_err(err[0]), .o_rd_data(rd[0]), .o_bus_en(b_en[0]),
    .o_bus_wr_en(b_wr[0]), .o_bus_addr(b_addr[0]), .o_bus_wr_data(b_wd[0]),
    .o_bus_byte_en(b_be[0]), .i_bus_rd_data(bus_rd), .i_bus_ack(bus_ack)
  );

  bus_arbiter #(.XLEN(XL), .NUM_MASTERS(N), .RR_ARB(0), .TIMEOUT(0), .ALIGN_WRITES(1)) dut_fp (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr_en(wr), .i_addr(addr), .i_wr_data(wd),
    .i_byte_en(be), .o_ready(rdy[1]), .o_err(err[1]), .o_rd_data(rd[1]), .o_bus_en(b_en[1]),
    .o_bus_wr_en(b_wr[1]), .o_bus_addr(b_addr[1]), .o_bus_wr_data(b_wd[1]),
    .o_bus_byte_en(b_be[1]), .i_bus_rd_data(bus_rd), .i_bus_ack(bus_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mbusy[m] = 1'b0; mwr[m] = 1'b0; mgnt[m] = 0; mptr[m] = 0; mcnt[m] = 0;
      maddr[m] = '0; mwd[m] = '0; mbe[m] = '0;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s_m%0d_resp", tag, m), {rdy[m], err[m], rd[m], b_en[m], b_wr[m]}, '0);
      check($sformatf("%s_m%0d_bus", tag, m), {b_addr[m], b_wd[m]}, '0);
      check($sformatf("%s_m%0d_be", tag, m), b_be[m], '0);
    end
  endtask

  // Compares this cycle's outputs against the model, then advances the model across the next edge.
  task automatic step(input bit upd);
    for (int m = 0; m < 2; m++) begin
      int lim, g, s;
      logic ack, tmo, live;
      logic [N-1:0] e_rdy;
      lim = m == 0 ? TO0 : 0;
      ack = mbusy[m] && bus_ack;
      tmo = lim > 0 && mbusy[m] && mcnt[m] == lim;
      live = mbusy[m] && req[mgnt[m]];
      e_rdy = (ack || tmo) && live ? N'(1) << mgnt[m] : '0;
      check($sformatf("m%0d_bus_en", m), b_en[m], mbusy[m]);
      check($sformatf("m%0d_bus_wr", m), b_wr[m], mwr[m]);
      check($sformatf("m%0d_bus_addr", m), b_addr[m], maddr[m]);
      check($sformatf("m%0d_bus_wd", m), b_wd[m], mwd[m]);
      check($sformatf("m%0d_bus_be", m), b_be[m], mbe[m]);
      check($sformatf("m%0d_ready", m), rdy[m], e_rdy);
      check($sformatf("m%0d_err", m), err[m], tmo && !ack ? e_rdy : '0);
      check($sformatf("m%0d_rd_data", m), rd[m], ack && live ? bus_rd : '0);
      if (upd) begin
        if (!mbusy[m] && |req) begin
          s = m == 0 ? mptr[m] : 0;
          g = 0;
          for (int j = N - 1; j >= 0; j--) if (req[(s + j) % N]) g = (s + j) % N;
          mbusy[m] = 1'b1; mgnt[m] = g; mcnt[m] = 1; mwr[m] = wr[g];
          maddr[m] = addr[g*XL +: XL];
          if (wr[g]) maddr[m][1:0] = 2'b00;
          mwd[m] = wd[g*XL +: XL];
          mbe[m] = be[g*4 +: 4];
        end else if (ack || tmo) begin
          mbusy[m] = 1'b0; mptr[m] = (mgnt[m] + 1) % N; mcnt[m] = 0;
          mwr[m] = 1'b0; maddr[m] = '0; mwd[m] = '0; mbe[m] = '0;
        end else if (mbusy[m]) mcnt[m]++;
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < N; r++) begin
        if (req[r] ? $urandom_range(5) == 0 : $urandom_range(2) == 0) begin
          req[r] = ~req[r];
          if (req[r]) begin
            wr[r] = 1'($urandom);
            addr[r*XL +: XL] = 32'($urandom);
            wd[r*XL +: XL] = 32'($urandom);
            be[r*4 +: 4] = 4'($urandom);
          end
        end
      end
      bus_ack = $urandom_range(2) == 0;
      bus_rd = 32'($urandom);
      #1;
      if (i == 700 || i == 1900) begin
        step(1'b0);
        #2 rst = 1'b1;
        #1 chk_zero($sformatf("async_rst%0d", i));
        model_reset();
      end else step(1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
